fir_mac_nch: RTL

Parametrised multi-channel FIR multiply-accumulate engine, the next generation of the per-band stereo filter in the equalizer chain. Each filter run streams one history sample per tap per channel from the upstream sample queue, multiplies it by a coefficient fetched from an external synchronous coefficient ROM, and accumulates over all taps. At the end of the run it emits one filtered sample per channel with a single-cycle valid strobe. Instances sit between the sample queue and the band-gain/summing stage, one per band.

---
 rtl/fir_mac_nch.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fir_mac_nch.sv
// fir_mac_nch: multi-channel FIR multiply-accumulate engine.
// Each run reads NTAPS coefficients from an external synchronous ROM.
// In each tap it multiplies the coefficient with one sample per channel.
// At the end of the run it emits one filtered sample per channel.
// Optional feature macro: FIR_SAT_EN.
//   Defined: each channel's output saturates, and a sat_flag port is added.
//   Undefined: each output is a plain truncated slice that wraps.
module fir_mac_nch #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int NTAPS = 1023,
  parameter int NCH   = 2,
  parameter int FRAC  = 15,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sequencing,
  input  logic [NCH*DW-1:0] smpl_in,
  input  logic [CW-1:0]     coef_in,
  output logic [AW-1:0]     coef_addr,
  output logic              smpl_req,
  output logic [NCH*DW-1:0] smpl_out,
  output logic              out_vld,
  output logic              busy
`ifdef FIR_SAT_EN
  ,
  output logic [NCH-1:0]    sat_flag
`endif
);

  localparam int ACCW = DW + CW + $clog2(NTAPS);
  localparam int XW   = ACCW - DW - CW;
  localparam int HIW  = ACCW - (FRAC + DW - 1);
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, WAIT_LOW} state_t;

  state_t            state_q, state_d;
  logic              seq_q;
  logic [AW-1:0]     addr_q, addr_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              out_vld_q, out_vld_d;
  logic [NCH*DW-1:0] out_q, out_d;
  logic [ACCW-1:0]   acc_q [NCH];
  logic [ACCW-1:0]   acc_d [NCH];
  logic [NCH*DW-1:0] res;
  logic              start;
  logic              clr;
`ifdef FIR_SAT_EN
  logic [NCH-1:0]    clamp;
  logic [NCH-1:0]    sat_q, sat_d;
`endif

  assign start = sequencing & ~seq_q;
  assign clr   = (state_q == IDLE) && start;

  // Per-channel MAC datapath and output slicing.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic signed [DW+CW-1:0] prod;
    logic                    unused_acc;
    assign prod = $signed(coef_in) * $signed(smpl_in[gi*DW +: DW]);
    // The accumulator is cleared on an accepted start.
    // It adds one product in each cycle in which a sample is consumed.
    assign acc_d[gi] = clr   ? '0 :
                       vld_q ? acc_q[gi] + {{XW{prod[DW+CW-1]}}, prod} :
                               acc_q[gi];
    // Only the output window of the accumulator is sampled.
    // The other bits are folded into this signal so they count as read.
    assign unused_acc = ^acc_q[gi];
`ifdef FIR_SAT_EN
    logic [HIW-1:0] hi;
    assign hi = acc_q[gi][ACCW-1:FRAC+DW-1];
    // If the bits above the window are not all copies of the sign bit,
    // the value does not fit in DW bits.
    assign clamp[gi] = ~((&hi) | ~(|hi));
    assign res[gi*DW +: DW] = !clamp[gi]       ? acc_q[gi][FRAC+DW-1:FRAC] :
                              acc_q[gi][ACCW-1] ? {1'b1, {(DW-1){1'b0}}} :
                                                  {1'b0, {(DW-1){1'b1}}};
`else
    assign res[gi*DW +: DW] = acc_q[gi][FRAC+DW-1:FRAC];
`endif
  end

  // Next-state logic for the sequencer, the outputs and the output capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    vld_d     = 1'b0;
    busy_d    = busy_q;
    out_vld_d = 1'b0;
    out_d     = out_q;
`ifdef FIR_SAT_EN
    sat_d     = sat_q;
`endif
    case (state_q)
      IDLE: begin
        addr_d = '0;
        busy_d = 1'b0;
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (!sequencing) begin
          state_d = IDLE;
          addr_d  = '0;
          busy_d  = 1'b0;
        end else begin
          // The sample for this address is consumed one cycle later.
          vld_d = 1'b1;
          if (addr_q == LAST) begin
            state_d = DRAIN;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!sequencing) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d   = WAIT_LOW;
        busy_d    = 1'b0;
        out_vld_d = 1'b1;
        out_d     = res;
`ifdef FIR_SAT_EN
        sat_d     = clamp;
`endif
      end
      WAIT_LOW: begin
        if (!sequencing) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      seq_q     <= 1'b0;
      addr_q    <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
`ifdef FIR_SAT_EN
      sat_q     <= '0;
`endif
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
    end else begin
      state_q   <= state_d;
      seq_q     <= sequencing;
      addr_q    <= addr_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
`ifdef FIR_SAT_EN
      sat_q     <= sat_d;
`endif
      for (int c = 0; c < NCH; c++) acc_q[c] <= acc_d[c];
    end
  end

  assign coef_addr = addr_q;
  assign smpl_req  = vld_q;
  assign smpl_out  = out_q;
  assign out_vld   = out_vld_q;
  assign busy      = busy_q;
`ifdef FIR_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule
